// File: rtl/rx_ctrl_pkg.sv
// rtl/rx_ctrl_pkg.sv - shared constants and types for the RxUnit APB controller
//
// Purpose: register byte offsets, CTRL/STATUS bit positions, the controller
// FSM state type, RxUnit baud/parity codes and the FIFO entry layout.
// Ports: none (package).
package rx_ctrl_pkg;

  // Register byte offsets; decode uses paddr[3:2], bits [1:0] are ignored.
  localparam logic [3:0] ADDR_CTRL   = 4'h0;
  localparam logic [3:0] ADDR_STATUS = 4'h4;
  localparam logic [3:0] ADDR_DATA   = 4'h8;
  localparam logic [3:0] ADDR_CLEAR  = 4'hC;

  // CTRL bit positions
  localparam int CTRL_ENABLE     = 0;
  localparam int CTRL_BAUD_LSB   = 1;
  localparam int CTRL_PARITY_LSB = 3;
  localparam int CTRL_IRQ_EN     = 5;
  localparam int CTRL_W          = 6;

  // STATUS bit positions; the count field starts at STAT_COUNT_LSB
  localparam int STAT_NOT_EMPTY   = 0;
  localparam int STAT_FULL        = 1;
  localparam int STAT_OVERRUN     = 2;
  localparam int STAT_CFG_PENDING = 3;
  localparam int STAT_RX_ACTIVE   = 4;
  localparam int STAT_COUNT_LSB   = 5;

  // CLEAR bit positions
  localparam int CLR_OVERRUN = 0;
  localparam int CLR_FLUSH   = 1;

  // RxUnit encodings
  localparam logic [1:0] BAUD_9600   = 2'b10;
  localparam logic [1:0] BAUD_19200  = 2'b11;
  localparam logic [1:0] PARITY_ODD  = 2'b01;
  localparam logic [1:0] PARITY_EVEN = 2'b10;

  // FIFO entry: {error[2:0], data[7:0]}
  localparam int ENTRY_W = 11;

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    ARMED    = 2'd1,
    BUSY     = 2'd2
  } rx_state_e;

  function automatic logic [ENTRY_W-1:0] pack_entry(input logic [2:0] err,
                                                    input logic [7:0] data);
    return {err, data};
  endfunction

endpackage

// File: rtl/rx_frame_fifo.sv
// rtl/rx_frame_fifo.sv - synchronous frame FIFO with push/pop/flush
//
// Purpose: DEPTH-entry buffer of ENTRY_W-bit received frames.
// Ports:
//   clock, reset      - clock, asynchronous active-high reset
//   push, wdata       - write request and entry; ignored when full unless
//                       a pop is accepted in the same cycle
//   pop, rdata        - read request and head entry (rdata is show-ahead)
//   flush             - empties the FIFO; overrides push and pop
//   full, empty, count- occupancy
module rx_frame_fifo
  import rx_ctrl_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               push,
  input  logic               pop,
  input  logic               flush,
  input  logic [ENTRY_W-1:0] wdata,
  output logic [ENTRY_W-1:0] rdata,
  output logic               full,
  output logic               empty,
  output logic [CNT_W-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               do_push;
  logic               do_pop;

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));
  assign rdata = mem[rd_ptr];

  assign do_pop  = pop & ~empty & ~flush;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push = push & (~full | do_pop) & ~flush;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // DEPTH is a power of two, so pointer overflow is the modulo wrap.
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/rx_ctrl_apb.sv
// rtl/rx_ctrl_apb.sv - APB controller, config sequencer and frame buffer for RxUnit
//
// Purpose: holds baud/parity/enable configuration, applies it to RxUnit only
// between frames, captures completed frames into a FIFO and raises irq.
// Ports:
//   clock, reset                       - clock, asynchronous active-high reset
//   psel, penable, pwrite, paddr,
//   pwdata, prdata, pready, pslverr    - APB slave (zero wait states)
//   rx_reset_n, rx_baud_rate,
//   rx_parity_type                     - registered RxUnit controls
//   rx_active, rx_done, rx_error,
//   rx_data                            - RxUnit status and received frame
//   irq                                - registered interrupt request
module rx_ctrl_apb
  import rx_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [3:0]  paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr,
  output logic        rx_reset_n,
  output logic [1:0]  rx_baud_rate,
  output logic [1:0]  rx_parity_type,
  input  logic        rx_active,
  input  logic        rx_done,
  input  logic [2:0]  rx_error,
  input  logic [7:0]  rx_data,
  output logic        irq
);

  logic [CTRL_W-1:0]  ctrl;
  logic               cfg_pending;
  logic               overrun;
  logic               done_prev;
  rx_state_e          state;

  logic               fifo_full;
  logic               fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  logic [ENTRY_W-1:0] fifo_rdata;

  logic               access;
  logic [3:0]         reg_addr;
  logic               ctrl_wr;
  logic               clear_wr;
  logic               data_rd;
  logic               push_req;
  logic               flush;
  logic               ovr_clear;
  logic               cfg_apply;
  logic [31:0]        status_word;
  logic               unused_bits;

  assign unused_bits = &{1'b0, pwdata[31:CTRL_W], paddr[1:0]};

  assign pready   = 1'b1;
  assign access   = psel & penable;
  assign reg_addr = {paddr[3:2], 2'b00};

  always_comb begin
    status_word                                 = '0;
    status_word[STAT_NOT_EMPTY]                 = ~fifo_empty;
    status_word[STAT_FULL]                      = fifo_full;
    status_word[STAT_OVERRUN]                   = overrun;
    status_word[STAT_CFG_PENDING]               = cfg_pending;
    status_word[STAT_RX_ACTIVE]                 = rx_active;
    status_word[STAT_COUNT_LSB +: CNT_W]        = fifo_count;
  end

  // Register access decode; everything is qualified by the access phase so
  // prdata/pslverr are 0 outside it.
  always_comb begin
    prdata   = '0;
    pslverr  = 1'b0;
    ctrl_wr  = 1'b0;
    clear_wr = 1'b0;
    data_rd  = 1'b0;
    if (access) begin
      case (reg_addr)
        ADDR_CTRL: begin
          if (pwrite) ctrl_wr = 1'b1;
          else        prdata  = 32'(ctrl);
        end
        ADDR_STATUS: begin
          if (pwrite) pslverr = 1'b1;
          else        prdata  = status_word;
        end
        ADDR_DATA: begin
          if (pwrite || fifo_empty) begin
            pslverr = 1'b1;
          end else begin
            prdata  = 32'(fifo_rdata);
            data_rd = 1'b1;
          end
        end
        ADDR_CLEAR: begin
          if (pwrite) clear_wr = 1'b1;
          else        pslverr  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign flush     = clear_wr & pwdata[CLR_FLUSH];
  assign ovr_clear = clear_wr & pwdata[CLR_OVERRUN];
  assign push_req  = rx_done & ~done_prev & (state != DISABLED);
  // Configuration is only allowed to reach RxUnit between frames.
  assign cfg_apply = (state == DISABLED) || (state == ARMED);

  rx_frame_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push_req),
    .pop   (data_rd),
    .flush (flush),
    .wdata (pack_entry(rx_error, rx_data)),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ctrl        <= '0;
      cfg_pending <= 1'b0;
      overrun     <= 1'b0;
      done_prev   <= 1'b0;
      irq         <= 1'b0;
    end else begin
      done_prev <= rx_done;
      // A write landing on an apply cycle wins: the new value is applied next cycle.
      if (ctrl_wr) begin
        ctrl        <= pwdata[CTRL_W-1:0];
        cfg_pending <= 1'b1;
      end else if (cfg_apply) begin
        cfg_pending <= 1'b0;
      end
      // A full FIFO loses the frame unless a pop frees a slot this cycle;
      // a flush discards the push without counting it as an overrun.
      if (push_req && fifo_full && !data_rd && !flush) overrun <= 1'b1;
      else if (ovr_clear)                              overrun <= 1'b0;
      irq <= ctrl[CTRL_IRQ_EN] & (~fifo_empty | overrun);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= DISABLED;
      rx_reset_n     <= 1'b0;
      rx_baud_rate   <= '0;
      rx_parity_type <= '0;
    end else begin
      if (cfg_apply) begin
        rx_baud_rate   <= ctrl[CTRL_BAUD_LSB +: 2];
        rx_parity_type <= ctrl[CTRL_PARITY_LSB +: 2];
      end
      case (state)
        DISABLED: begin
          if (ctrl[CTRL_ENABLE]) begin
            state      <= ARMED;
            rx_reset_n <= 1'b1;
          end
        end
        ARMED: begin
          if (!ctrl[CTRL_ENABLE]) begin
            state      <= DISABLED;
            rx_reset_n <= 1'b0;
          end else if (rx_active) begin
            state <= BUSY;
          end
        end
        // Disable requests wait here until the frame finishes; ARMED then
        // handles the drop to DISABLED.
        BUSY: begin
          if (!rx_active) state <= ARMED;
        end
        default: begin
          state      <= DISABLED;
          rx_reset_n <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rx_ctrl_apb.sv
// tb/tb_rx_ctrl_apb.sv - self-checking bench for rx_ctrl_apb
module tb_rx_ctrl_apb;
  import rx_ctrl_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [3:0]  paddr = '0;
  logic [31:0] pwdata = '0;
  logic [31:0] prdata;
  logic        pready, pslverr;
  logic        rx_reset_n;
  logic [1:0]  rx_baud_rate, rx_parity_type;
  logic        rx_active = 1'b0, rx_done = 1'b0;
  logic [2:0]  rx_error = '0;
  logic [7:0]  rx_data = '0;
  logic        irq;

  int checks = 0;
  int failures = 0;

  rx_ctrl_apb #(.FIFO_DEPTH(4), .CNT_W(3)) dut (
    .clock(clock), .reset(reset), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .rx_reset_n(rx_reset_n), .rx_baud_rate(rx_baud_rate), .rx_parity_type(rx_parity_type),
    .rx_active(rx_active), .rx_done(rx_done), .rx_error(rx_error), .rx_data(rx_data),
    .irq(irq)
  );

  always #10 clock = ~clock;

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        w;
    logic [3:0]  a;
    logic [31:0] d;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clock);
  endtask

  // Two-cycle APB transfer starting and ending on a falling edge.
  task automatic apb(input logic w, input logic [3:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic err);
    psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d;
    @(negedge clock);
    penable = 1'b1;
    #1;
    rd  = prdata;
    err = pslverr;
    @(negedge clock);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input string name);
    logic [31:0] rd;
    logic        err;
    apb(1'b1, a, d, rd, err);
    check({name, "_pslverr"}, 32'(err), 32'd0);
  endtask

  task automatic rd_chk(input logic [3:0] a, input logic [31:0] exp_d, input logic exp_e,
                        input string name);
    logic [31:0] rd;
    logic        err;
    apb(1'b0, a, 32'd0, rd, err);
    check({name, "_prdata"}, rd, exp_d);
    check({name, "_pslverr"}, 32'(err), 32'(exp_e));
  endtask

  task automatic frame(input logic [7:0] d, input logic [2:0] e);
    rx_data = d; rx_error = e; rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick();
  endtask

  // STATUS word assembled from the documented field layout.
  function automatic logic [31:0] st(input bit ne, input bit full, input bit ovr,
                                     input bit pend, input bit act, input int cnt);
    return 32'(ne) | (32'(full) << 1) | (32'(ovr) << 2) | (32'(pend) << 3) |
           (32'(act) << 4) | (32'(cnt) << 5);
  endfunction

  vec_t        vecs[13];
  logic [10:0] q[$];
  bit          m_ovr;

  initial begin
    logic [31:0] rd;
    logic        err;

    vecs[0]  = '{1'b0, 4'h0, 32'h0,         32'h0,  1'b0};
    vecs[1]  = '{1'b0, 4'h4, 32'h0,         32'h0,  1'b0};
    vecs[2]  = '{1'b0, 4'h8, 32'h0,         32'h0,  1'b1};
    vecs[3]  = '{1'b0, 4'hC, 32'h0,         32'h0,  1'b1};
    vecs[4]  = '{1'b1, 4'h4, 32'hFF,        32'h0,  1'b1};
    vecs[5]  = '{1'b1, 4'h8, 32'hFF,        32'h0,  1'b1};
    vecs[6]  = '{1'b0, 4'h4, 32'h0,         32'h0,  1'b0};
    vecs[7]  = '{1'b1, 4'h0, 32'hFFFF_FFCD, 32'h0,  1'b0};
    vecs[8]  = '{1'b0, 4'h0, 32'h0,         32'h0D, 1'b0};
    vecs[9]  = '{1'b1, 4'h0, 32'h0,         32'h0,  1'b0};
    vecs[10] = '{1'b0, 4'h3, 32'h0,         32'h0,  1'b0};
    vecs[11] = '{1'b1, 4'hC, 32'h3,         32'h0,  1'b0};
    vecs[12] = '{1'b0, 4'h6, 32'h0,         32'h0,  1'b0};

    tick(3);
    reset = 1'b0;
    tick();
    check("rst_rx_reset_n", 32'(rx_reset_n), 32'd0);
    check("rst_baud", 32'(rx_baud_rate), 32'd0);
    check("rst_parity", 32'(rx_parity_type), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_pready", 32'(pready), 32'd1);
    check("rst_prdata", prdata, 32'd0);
    check("rst_pslverr", 32'(pslverr), 32'd0);

    for (int i = 0; i < 13; i++) begin
      apb(vecs[i].w, vecs[i].a, vecs[i].d, rd, err);
      check($sformatf("vec%0d_prdata", i), rd, vecs[i].exp_rd);
      check($sformatf("vec%0d_pslverr", i), 32'(err), 32'(vecs[i].exp_err));
    end

    // Config and enable
    do_reset();
    wr(4'h0, 32'h0D, "en_wr");
    tick();
    check("en_rx_reset_n", 32'(rx_reset_n), 32'd1);
    check("en_baud", 32'(rx_baud_rate), 32'(BAUD_9600));
    check("en_parity", 32'(rx_parity_type), 32'(PARITY_ODD));
    rd_chk(4'h4, st(0, 0, 0, 0, 0, 0), 1'b0, "en_status");

    // Config change during a frame
    rx_active = 1'b1;
    tick();
    wr(4'h0, 32'h17, "busy_wr");
    check("busy_baud_frozen", 32'(rx_baud_rate), 32'(BAUD_9600));
    rd_chk(4'h4, st(0, 0, 0, 1, 1, 0), 1'b0, "busy_status");
    check("busy_baud_still", 32'(rx_baud_rate), 32'(BAUD_9600));
    check("busy_parity_still", 32'(rx_parity_type), 32'(PARITY_ODD));
    rx_active = 1'b0;
    for (int i = 0; i < 6 && rx_baud_rate != BAUD_19200; i++) tick();
    check("idle_baud", 32'(rx_baud_rate), 32'(BAUD_19200));
    check("idle_parity", 32'(rx_parity_type), 32'(PARITY_EVEN));
    rd_chk(4'h4, st(0, 0, 0, 0, 0, 0), 1'b0, "idle_status");

    // Single capture with rx_done held for three cycles
    rx_data = 8'hB2; rx_error = 3'b000; rx_done = 1'b1;
    tick(3);
    rx_done = 1'b0;
    tick();
    rd_chk(4'h4, st(1, 0, 0, 0, 0, 1), 1'b0, "cap_status");
    rd_chk(4'h8, 32'h0B2, 1'b0, "cap_data");
    rd_chk(4'h4, st(0, 0, 0, 0, 0, 0), 1'b0, "cap_status_after");

    // Overrun
    for (int i = 1; i <= 5; i++) frame(8'(i), 3'b000);
    rd_chk(4'h4, st(1, 1, 1, 0, 0, 4), 1'b0, "ovr_status");
    check("ovr_irq_disabled", 32'(irq), 32'd0);
    for (int i = 1; i <= 4; i++) rd_chk(4'h8, 32'(i), 1'b0, $sformatf("ovr_data%0d", i));
    rd_chk(4'h8, 32'h0, 1'b1, "ovr_empty_read");
    wr(4'hC, 32'h1, "ovr_clear");
    rd_chk(4'h4, st(0, 0, 0, 0, 0, 0), 1'b0, "ovr_status_cleared");

    // Simultaneous pop and push on a full FIFO
    for (int i = 0; i < 4; i++) frame(8'h10 + 8'(i), 3'b000);
    rd_chk(4'h4, st(1, 1, 0, 0, 0, 4), 1'b0, "sim_status_full");
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 4'h8;
    tick();
    penable = 1'b1; rx_data = 8'h7E; rx_error = 3'b000; rx_done = 1'b1;
    #1;
    check("sim_pop_data", prdata, 32'h010);
    check("sim_pop_err", 32'(pslverr), 32'd0);
    tick();
    psel = 1'b0; penable = 1'b0; rx_done = 1'b0;
    tick();
    rd_chk(4'h4, st(1, 1, 0, 0, 0, 4), 1'b0, "sim_status_after");
    rd_chk(4'h8, 32'h011, 1'b0, "sim_d1");
    rd_chk(4'h8, 32'h012, 1'b0, "sim_d2");
    rd_chk(4'h8, 32'h013, 1'b0, "sim_d3");
    rd_chk(4'h8, 32'h07E, 1'b0, "sim_tail");

    // Interrupt and flush
    wr(4'h0, 32'h21, "irq_wr");
    check("irq_idle", 32'(irq), 32'd0);
    rx_data = 8'h5A; rx_error = 3'b101; rx_done = 1'b1;
    tick();
    check("irq_push_cycle", 32'(irq), 32'd0);
    tick();
    rx_done = 1'b0;
    check("irq_after_push", 32'(irq), 32'd1);
    wr(4'hC, 32'h2, "irq_flush");
    check("irq_flush_edge", 32'(irq), 32'd1);
    tick();
    check("irq_after_flush", 32'(irq), 32'd0);
    rd_chk(4'h4, st(0, 0, 0, 0, 0, 0), 1'b0, "flush_status");

    // Reset mid-frame
    wr(4'h0, 32'h0D, "rst_mid_wr");
    frame(8'h33, 3'b000);
    rx_active = 1'b1;
    tick();
    reset = 1'b1;
    #1;
    check("rst_mid_rx_reset_n", 32'(rx_reset_n), 32'd0);
    tick();
    reset = 1'b0; rx_active = 1'b0;
    tick();
    rd_chk(4'h4, st(0, 0, 0, 0, 0, 0), 1'b0, "rst_mid_status");
    rd_chk(4'h0, 32'h0, 1'b0, "rst_mid_ctrl");

    // Randomized traffic against a queue model
    do_reset();
    wr(4'h0, 32'h21, "rand_en");
    tick();
    q.delete();
    m_ovr = 0;
    for (int n = 0; n < 300; n++) begin
      int op;
      op = int'($urandom_range(0, 9));
      if (op < 4) begin
        logic [7:0] d;
        logic [2:0] e;
        d = 8'($urandom);
        e = 3'($urandom);
        frame(d, e);
        if (q.size() < 4) q.push_back({e, d});
        else m_ovr = 1;
      end else if (op < 7) begin
        if (q.size() == 0) begin
          rd_chk(4'h8, 32'h0, 1'b1, "rand_data_empty");
        end else begin
          logic [10:0] exp_e;
          exp_e = q.pop_front();
          rd_chk(4'h8, 32'(exp_e), 1'b0, "rand_data");
        end
      end else if (op == 7) begin
        rd_chk(4'h4, st(q.size() != 0, q.size() == 4, m_ovr, 0, 0, q.size()), 1'b0,
               "rand_status");
      end else if (op == 8) begin
        logic [1:0] c;
        c = 2'($urandom);
        wr(4'hC, 32'(c), "rand_clear");
        if (c[1]) q.delete();
        if (c[0]) m_ovr = 0;
      end else begin
        tick();
      end
      tick();
      check("rand_irq", 32'(irq), 32'(q.size() != 0 || m_ovr));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rx_ctrl_apb.md
Name: rx_ctrl_apb

Overview:
- APB-facing controller that configures and sequences the UART receive unit (RxUnit) and buffers its received frames.
- Owns the baud/parity configuration and applies it to RxUnit only between frames.
- Captures each completed frame with its error code into a small FIFO, tracks overrun, and raises an interrupt.
- Sits between the APB bus and RxUnit.

Parameters:
FIFO_DEPTH, 4, receive FIFO entries; power of 2, at least 2
CNT_W, 3, width of the occupancy count; equals log2(FIFO_DEPTH)+1

Ports:
clock  in  1  system clock (50 MHz)
reset  in  1  asynchronous, active-high reset
psel  in  1  APB select
penable  in  1  APB enable (access phase)
pwrite  in  1  APB write
paddr  in  4  APB byte address; word-aligned, bits[1:0] ignored
pwdata  in  32  APB write data
prdata  out  32  APB read data
pready  out  1  APB ready; tied to 1 (zero wait states)
pslverr  out  1  APB error
rx_reset_n  out  1  active-low reset to RxUnit
rx_baud_rate  out  2  RxUnit baud_rate select
rx_parity_type  out  2  RxUnit parity_type select
rx_active  in  1  RxUnit active_flag
rx_done  in  1  RxUnit done_flag; may stay high for several cycles
rx_error  in  3  RxUnit error_flag
rx_data  in  8  RxUnit data_out
irq  out  1  interrupt request (registered)

Behaviour:
- Register map:
  - 0x0 CTRL (RW): [0] enable, [2:1] baud, [4:3] parity, [5] irq_en.
  - 0x4 STATUS (RO): [0] not_empty, [1] full, [2] overrun, [3] cfg_pending, [4] rx_active, [4+CNT_W:5] count.
  - 0x8 DATA (RO, read pops the FIFO): [7:0] data, [10:8] error.
  - 0xC CLEAR (WO): bit0=1 clears overrun; bit1=1 flushes the FIFO.
  - All other addresses: read 0 with pslverr=0; writes ignored.
- APB transfers:
  - Each transfer completes in its access cycle (psel&penable).
  - prdata and pslverr are combinational during the access cycle; otherwise both are 0.
  - Write to a RO register, or read of a WO register: ignored, pslverr=1.
  - Read of DATA when the FIFO is empty: prdata=0, pslverr=1, no pop.
- CTRL writes:
  - Update the shadow register immediately and set cfg_pending.
  - Shadow values propagate to rx_baud_rate/rx_parity_type only in states DISABLED or ARMED.
  - cfg_pending clears on the cycle the values are applied.
- FSM (registered):
  - DISABLED: rx_reset_n=0; apply config. Go to ARMED when enable=1.
  - ARMED: rx_reset_n=1; apply pending config. Go to BUSY when rx_active=1; go to DISABLED when enable=0.
  - BUSY: config frozen. Go to ARMED when rx_active falls.
  - enable=0 written during BUSY: the current frame completes, then the FSM goes to ARMED and on to DISABLED.
- Frame capture:
  - A frame is captured on the rising edge of rx_done (registered previous value), in any state except DISABLED.
  - The FIFO entry is {rx_error, rx_data}.
- FIFO boundary rules:
  - Push when full: frame dropped, overrun set (sticky).
  - Push and pop in the same cycle: both succeed and count is unchanged; this includes the full case, where no overrun is set.
  - Flush and push in the same cycle: flush wins, push is dropped, overrun unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- irq = registered (irq_en & (not_empty | overrun)).
- Reset values:
  - CTRL=0; pointers, count, overrun and cfg_pending = 0.
  - FSM=DISABLED; rx_reset_n=0; rx_baud_rate=0; rx_parity_type=0.
  - irq=0, prdata=0, pslverr=0, pready=1.
- Asserting reset mid-frame discards everything immediately.

Decomposition:
- Package rx_ctrl_pkg holds:
  - register offset constants (CTRL/STATUS/DATA/CLEAR);
  - CTRL and STATUS bit-index constants;
  - the FSM state enum (DISABLED/ARMED/BUSY);
  - baud and parity code constants matching RxUnit encoding (parity 01=odd, 10=even; baud 10=9600, 11=19200).
- One sub-module, rx_frame_fifo: synchronous FIFO, 11-bit wide and FIFO_DEPTH deep, with push/pop/flush ports and full/empty/count outputs.

Test Plan:
- Config and enable:
  - Stimulus: reset, then write CTRL=0x0D (enable, baud=10, parity=01).
  - Response: next cycle FSM=ARMED, rx_reset_n=1, rx_baud_rate=10, rx_parity_type=01, cfg_pending=0.
- Config change during a frame:
  - Stimulus: rx_active=1, then write CTRL baud=11 and parity=10.
  - Response: rx_baud_rate stays 10 and cfg_pending=1 until rx_active falls; then rx_baud_rate=11 and cfg_pending=0.
- Single capture:
  - Stimulus: rx_done held high for 3 cycles with rx_data=0xB2, rx_error=000.
  - Response: exactly one push, count=1, not_empty=1.
  - DATA read returns 0x0B2, then count=0.
- Overrun:
  - Stimulus: 5 rx_done pulses (0x01..0x05) with no reads.
  - Response: full=1 and overrun=1; reads return 0x01..0x04.
  - 5th read: pslverr=1, prdata=0.
  - CLEAR=0x1 clears overrun.
- Simultaneous events:
  - Stimulus: FIFO full, DATA read in the same cycle as an rx_done rising edge carrying 0x7E.
  - Response: count stays 4, overrun=0, 0x7E is at the tail.
- Interrupt and flush:
  - Stimulus: irq_en=1, one frame received.
  - Response: irq=1 one cycle after the push.
  - CLEAR=0x2 leaves count=0, and irq=0 on the following cycle.
